// File: rtl/ray_march_pkg.sv
// Shared Q16.16 fixed-point types, march constants and FSM state encoding
// for the sphere-tracing ray marcher.
package ray_march_pkg;

    localparam int FP_W    = 32;
    localparam int FP_FRAC = 16;

    typedef logic signed [FP_W-1:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    localparam fp_t FP_MAX      = 32'sh7FFF_FFFF;
    localparam fp_t FP_MIN      = 32'sh8000_0000;
    localparam fp_t FP_EPSILON  = 32'sd66;          // ~0.001
    localparam fp_t FP_MAX_DIST = 32'sh0064_0000;   // 100.0

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUERY,
        ST_STEP,
        ST_DONE
    } march_state_t;

    // Full-precision product, truncated back to Q16.16.
    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic signed [2*FP_W-1:0] prod;
        prod = (2*FP_W)'(a) * (2*FP_W)'(b);
        return prod[FP_FRAC +: FP_W];
    endfunction

    function automatic fp_t fp_add(input fp_t a, input fp_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/ray_march_advance.sv
// Combinational march advance: next point = point + dir * dist, per component.
module ray_march_advance
    import ray_march_pkg::*;
(
    input  vec3_t point_i,
    input  vec3_t dir_i,
    input  fp_t   dist_i,
    output vec3_t point_o
);

    always_comb begin
        point_o.x = fp_add(point_i.x, fp_mul(dir_i.x, dist_i));
        point_o.y = fp_add(point_i.y, fp_mul(dir_i.y, dist_i));
        point_o.z = fp_add(point_i.z, fp_mul(dir_i.z, dist_i));
    end

endmodule

// File: rtl/ray_march_core.sv
// Single-ray sphere-tracing core: alternates an external SDF query with a
// point advance until the surface is hit, the step budget runs out or the ray escapes.
module ray_march_core
    import ray_march_pkg::*;
#(
    parameter int  MAX_STEPS = 64,
    parameter int  TAG_W     = 16,
    parameter fp_t EPSILON   = FP_EPSILON,
    parameter fp_t MAX_DIST  = FP_MAX_DIST
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           ray_valid_in,
    output logic                           ray_ready_out,
    input  vec3_t                          ray_origin_in,
    input  vec3_t                          ray_dir_in,
    input  logic [TAG_W-1:0]               ray_tag_in,
    output vec3_t                          query_point_out,
    input  fp_t                            sdf_in,
    output logic                           result_valid_out,
    input  logic                           result_ready_in,
    output logic                           result_hit_out,
    output logic [$clog2(MAX_STEPS+1)-1:0] result_steps_out,
    output fp_t                            result_t_out,
    output vec3_t                          result_point_out,
    output logic [TAG_W-1:0]               result_tag_out
);

    localparam int STEP_W = $clog2(MAX_STEPS+1);

    march_state_t      state_q, state_d;
    vec3_t             point_q, point_d;
    vec3_t             dir_q, dir_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    fp_t               t_q, t_d;
    fp_t               dist_q, dist_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              hit_q, hit_d;

    vec3_t             point_adv;
    logic signed [FP_W:0] t_sum;
    fp_t               t_next;
    logic [STEP_W-1:0] steps_inc;

    ray_march_advance u_advance (
        .point_i (point_q),
        .dir_i   (dir_q),
        .dist_i  (dist_q),
        .point_o (point_adv)
    );

    // Distance accumulator clamps instead of wrapping so a far miss stays far.
    always_comb begin
        t_sum     = {t_q[FP_W-1], t_q} + {dist_q[FP_W-1], dist_q};
        t_next    = (t_sum[FP_W] != t_sum[FP_W-1]) ? (t_sum[FP_W] ? FP_MIN : FP_MAX)
                                                   : fp_t'(t_sum[FP_W-1:0]);
        steps_inc = steps_q + STEP_W'(1);
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d = state_q;
        point_d = point_q;
        dir_d   = dir_q;
        tag_d   = tag_q;
        t_d     = t_q;
        dist_d  = dist_q;
        steps_d = steps_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (ray_valid_in) begin
                    point_d = ray_origin_in;
                    dir_d   = ray_dir_in;
                    tag_d   = ray_tag_in;
                    t_d     = '0;
                    steps_d = '0;
                    hit_d   = 1'b0;
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                dist_d = sdf_in;
                if (sdf_in < EPSILON) begin
                    hit_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                point_d = point_adv;
                t_d     = t_next;
                steps_d = steps_inc;
                if (steps_inc == STEP_W'(MAX_STEPS) || t_next >= MAX_DIST) begin
                    hit_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_QUERY;
                end
            end
            ST_DONE: begin
                if (result_ready_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their _d values from the same edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            point_q <= '0;
            dir_q   <= '0;
            tag_q   <= '0;
            t_q     <= '0;
            dist_q  <= '0;
            steps_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            point_q <= point_d;
            dir_q   <= dir_d;
            tag_q   <= tag_d;
            t_q     <= t_d;
            dist_q  <= dist_d;
            steps_q <= steps_d;
            hit_q   <= hit_d;
        end
    end

    // Result fields are the march registers themselves; none move while in DONE.
    assign ray_ready_out    = (state_q == ST_IDLE) && !rst_in;
    assign result_valid_out = (state_q == ST_DONE);
    assign query_point_out  = point_q;
    assign result_hit_out   = hit_q;
    assign result_steps_out = steps_q;
    assign result_t_out     = t_q;
    assign result_point_out = point_q;
    assign result_tag_out   = tag_q;

endmodule

// File: tb/tb_ray_march_core.sv
// Scoreboard bench for ray_march_core: drivers push expected results, a
// negedge monitor compares every presented result against the queue head.
module tb_ray_march_core;
    import ray_march_pkg::*;

    localparam fp_t ONE  = 32'sh0001_0000;
    localparam fp_t HALF = 32'sh0000_8000;

    typedef struct {
        logic        hit;
        logic [7:0]  steps;
        fp_t         t;
        vec3_t       point;
        logic [15:0] tag;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_a, valid_b, res_ready;
    vec3_t       origin, dir;
    logic [15:0] tag;
    logic        ready_a, ready_b, rv_a, rv_b, hit_a, hit_b;
    vec3_t       qp_a, qp_b, pt_a, pt_b;
    fp_t         sdf_a, sdf_b, t_a, t_b;
    logic [6:0]  st_a;
    logic [2:0]  st_b;
    logic [15:0] tg_a, tg_b;

    int   sdf_mode;
    fp_t  sdf_const;
    int   cyc = 0;
    int   chk = 0;
    int   err = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    bit   prev_v[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ray_march_core #(.MAX_STEPS(64), .TAG_W(16), .EPSILON(FP_EPSILON), .MAX_DIST(32'sh0008_0000)) dut_a (
        .clk_in(clk), .rst_in(rst), .ray_valid_in(valid_a), .ray_ready_out(ready_a),
        .ray_origin_in(origin), .ray_dir_in(dir), .ray_tag_in(tag),
        .query_point_out(qp_a), .sdf_in(sdf_a),
        .result_valid_out(rv_a), .result_ready_in(res_ready), .result_hit_out(hit_a),
        .result_steps_out(st_a), .result_t_out(t_a), .result_point_out(pt_a),
        .result_tag_out(tg_a));

    ray_march_core #(.MAX_STEPS(4), .TAG_W(16), .EPSILON(FP_EPSILON), .MAX_DIST(FP_MAX_DIST)) dut_b (
        .clk_in(clk), .rst_in(rst), .ray_valid_in(valid_b), .ray_ready_out(ready_b),
        .ray_origin_in(origin), .ray_dir_in(dir), .ray_tag_in(tag),
        .query_point_out(qp_b), .sdf_in(sdf_b),
        .result_valid_out(rv_b), .result_ready_in(res_ready), .result_hit_out(hit_b),
        .result_steps_out(st_b), .result_t_out(t_b), .result_point_out(pt_b),
        .result_tag_out(tg_b));

    // Mode 0: axis-aligned cube of half-size 0.5 (Chebyshev form); mode 1: constant stub.
    function automatic fp_t sdf_eval(input vec3_t p, input int mode, input fp_t c);
        fp_t ax, ay, az, m;
        ax = (p.x < 0) ? -p.x : p.x;
        ay = (p.y < 0) ? -p.y : p.y;
        az = (p.z < 0) ? -p.z : p.z;
        m  = ax;
        if (ay > m) m = ay;
        if (az > m) m = az;
        return (mode == 0) ? (m - HALF) : c;
    endfunction

    always_comb sdf_a = sdf_eval(qp_a, sdf_mode, sdf_const);
    always_comb sdf_b = sdf_eval(qp_b, sdf_mode, sdf_const);

    function automatic vec3_t v3(input fp_t x, input fp_t y, input fp_t z);
        vec3_t v;
        v.x = x; v.y = y; v.z = z;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic r, input logic hit,
                       input logic [7:0] st, input fp_t t, input vec3_t p, input logic [15:0] tg);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (v === 1'b1) begin
            if (id == 0) begin
                have = (sb_a.size() != 0);
                if (have) e = sb_a[0];
            end else begin
                have = (sb_b.size() != 0);
                if (have) e = sb_b[0];
            end
            check($sformatf("dut%0d_result_expected", id), 128'(have), 128'(1));
            if (have) begin
                if (!prev_v[id]) check($sformatf("dut%0d_latency_tag%0h", id, e.tag), 128'(cyc - e.acc), 128'(e.lat));
                check($sformatf("dut%0d_hit_tag%0h", id, e.tag),   128'(hit), 128'(e.hit));
                check($sformatf("dut%0d_steps_tag%0h", id, e.tag), 128'(st),  128'(e.steps));
                check($sformatf("dut%0d_t_tag%0h", id, e.tag),     128'(t),   128'(e.t));
                check($sformatf("dut%0d_point_tag%0h", id, e.tag), 128'(p),   128'(e.point));
                check($sformatf("dut%0d_tag_tag%0h", id, e.tag),   128'(tg),  128'(e.tag));
                if (r === 1'b1) begin
                    if (id == 0) void'(sb_a.pop_front());
                    else         void'(sb_b.pop_front());
                end
            end
        end
        prev_v[id] = (v === 1'b1);
    endtask

    always @(negedge clk) begin
        mon(0, rv_a, res_ready, hit_a, {1'b0, st_a}, t_a, pt_a, tg_a);
        mon(1, rv_b, res_ready, hit_b, {5'b0, st_b}, t_b, pt_b, tg_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic h, input int s, input fp_t t,
                            input vec3_t p, input logic [15:0] tg, input int lat, input int acc);
        exp_t e;
        e.hit = h; e.steps = 8'(s); e.t = t; e.point = p; e.tag = tg; e.lat = lat; e.acc = acc;
        if (id == 0) sb_a.push_back(e);
        else         sb_b.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge following acceptance.
    task automatic send(input int id, input vec3_t o, input vec3_t d, input logic [15:0] tg,
                        input bit push, input logic h, input int s, input fp_t t,
                        input vec3_t p, input int lat, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        origin = o; dir = d; tag = tg;
        if (id == 0) valid_a = 1'b1;
        else         valid_b = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (((id == 0) ? ready_a : ready_b) === 1'b1) begin
                got = 1'b1;
                acc = cyc;
                if (push) push_exp(id, h, s, t, p, tg, lat, acc);
            end
            tick();
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        check($sformatf("dut%0d_accept_tag%0h", id, tg), 128'(got), 128'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sb_a.size() + sb_b.size()) != 0; i++) tick();
        check("scoreboard_drained", 128'(sb_a.size() + sb_b.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; res_ready = 1'b1;
        origin = '0; dir = '0; tag = '0;
        sdf_mode = 0; sdf_const = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_result_valid", 128'(rv_a), 128'(0));
        check("rst_ray_ready",    128'(ready_a), 128'(0));
        check("rst_hit",          128'(hit_a), 128'(0));
        check("rst_steps",        128'(st_a), 128'(0));
        check("rst_t",            128'(t_a), 128'(0));
        check("rst_point",        128'(pt_a), 128'(0));
        check("rst_tag",          128'(tg_a), 128'(0));
        check("rst_query_point",  128'(qp_a), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 128'(ready_a), 128'(1));
        tick();

        // Cube hits
        sdf_mode = 0;
        send(0, v3(0, 0, -3*ONE), v3(0, 0, ONE), 16'h0001, 1, 1, 1, 32'sh0002_8000, v3(0, 0, -HALF), 4, acc);
        drain();
        send(0, v3(0, 0, 0), v3(0, 0, ONE), 16'h0002, 1, 1, 0, 0, v3(0, 0, 0), 2, acc);
        drain();
        send(0, v3(-3*ONE, 0, 0), v3(HALF, 0, 0), 16'h0003, 1, 1, 12, 32'sd327600, v3(-32'sd32808, 0, 0), 26, acc);
        drain();
        send(0, v3(0, 3*ONE, 0), v3(0, -ONE, 0), 16'h0004, 1, 1, 1, 32'sh0002_8000, v3(0, HALF, 0), 4, acc);
        drain();

        // Distance-limited miss
        sdf_mode = 1; sdf_const = ONE;
        send(0, v3(0, 0, 0), v3(0, 0, ONE), 16'h0005, 1, 0, 8, 8*ONE, v3(0, 0, 8*ONE), 17, acc);
        drain();

        // Step-limited misses and epsilon boundary on the MAX_STEPS=4 core
        sdf_const = 2*FP_EPSILON;
        send(1, v3(0, 0, 0), v3(0, 0, ONE), 16'h0006, 1, 0, 4, 4*2*FP_EPSILON, v3(0, 0, 4*2*FP_EPSILON), 9, acc);
        drain();
        sdf_const = FP_EPSILON;
        send(1, v3(0, 0, 0), v3(0, 0, ONE), 16'h0007, 1, 0, 4, 4*FP_EPSILON, v3(0, 0, 4*FP_EPSILON), 9, acc);
        drain();
        sdf_const = FP_EPSILON - 1;
        send(1, v3(ONE, 2*ONE, -ONE), v3(0, 0, ONE), 16'h0008, 1, 1, 0, 0, v3(ONE, 2*ONE, -ONE), 2, acc);
        drain();
        sdf_const = -32'sd5;
        send(1, v3(0, ONE, 0), v3(ONE, 0, 0), 16'h0009, 1, 1, 0, 0, v3(0, ONE, 0), 2, acc);
        drain();

        // Back-pressure in DONE while new rays are offered
        sdf_mode = 0;
        res_ready = 1'b0;
        send(0, v3(0, 0, 0), v3(0, 0, ONE), 16'h0A0A, 1, 1, 0, 0, v3(0, 0, 0), 2, acc);
        for (int i = 0; i < 50 && rv_a !== 1'b1; i++) begin
            @(negedge clk);
            if (rv_a !== 1'b1) tick();
        end
        check("done_reached", 128'(rv_a), 128'(1));
        for (int i = 0; i < 10; i++) begin
            check("ready_low_in_done", 128'(ready_a), 128'(0));
            tick();
            valid_a = (i % 2 == 0);
            tag = 16'hBEEF;
            origin = v3(7*ONE, 7*ONE, 7*ONE);
            @(negedge clk);
        end
        tick();
        res_ready = 1'b1;
        valid_a = 1'b1;
        origin = v3(0, 0, -3*ONE); dir = v3(0, 0, ONE); tag = 16'h0B0B;
        @(negedge clk);
        check("ready_low_in_handshake", 128'(ready_a), 128'(0));
        tick();
        @(negedge clk);
        check("ready_after_handshake", 128'(ready_a), 128'(1));
        if (ready_a === 1'b1) push_exp(0, 1, 1, 32'sh0002_8000, v3(0, 0, -HALF), 16'h0B0B, 4, cyc);
        tick();
        valid_a = 1'b0;
        drain();

        // Reset during the third STEP aborts the ray
        sdf_mode = 1; sdf_const = ONE;
        send(0, v3(0, 0, 0), v3(0, 0, ONE), 16'hDEAD, 0, 0, 0, 0, v3(0, 0, 0), 0, acc);
        for (int i = 0; i < 20 && cyc != acc + 6; i++) tick();
        rst = 1'b1;
        @(negedge clk);
        check("pre_reset_point", 128'(qp_a), 128'(v3(0, 0, 2*ONE)));
        check("ready_low_in_reset", 128'(ready_a), 128'(0));
        tick();
        @(negedge clk);
        check("abort_result_valid", 128'(rv_a), 128'(0));
        check("abort_query_point",  128'(qp_a), 128'(0));
        check("abort_t",            128'(t_a), 128'(0));
        check("abort_steps",        128'(st_a), 128'(0));
        check("abort_tag",          128'(tg_a), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 128'(ready_a), 128'(1));
        tick();
        repeat (20) tick();
        sdf_mode = 0;
        send(0, v3(0, 0, -3*ONE), v3(0, 0, ONE), 16'h0C0C, 1, 1, 1, 32'sh0002_8000, v3(0, 0, -HALF), 4, acc);
        drain();

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule

// File: doc/ray_march_core.md
RAY_MARCH_CORE -- requirements
Module: ray_march_core

Interface
REQ-001 Parameter: MAX_STEPS, 64, iteration limit before a miss is declared.
REQ-002 Parameter: TAG_W, 16, width of the opaque per-ray tag (pixel id).
REQ-003 Parameter: EPSILON, FP_EPSILON, hit threshold in fp.
REQ-004 Parameter: MAX_DIST, FP_MAX_DIST, miss distance in fp.
REQ-005 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 ray_valid_in  input  1  ray request valid.
REQ-008 ray_ready_out  output  1  core can accept a ray.
REQ-009 ray_origin_in  input  vec3  ray start point.
REQ-010 ray_dir_in  input  vec3  unit ray direction.
REQ-011 ray_tag_in  input  TAG_W  tag returned unchanged with the result.
REQ-012 query_point_out  output  vec3  point presented to the external combinational SDF query.
REQ-013 sdf_in  input  fp  SDF distance for query_point_out, same cycle.
REQ-014 result_valid_out  output  1  result available.
REQ-015 result_ready_in  input  1  consumer accepts result.
REQ-016 result_hit_out  output  1  1 = surface hit, 0 = miss.
REQ-017 result_steps_out  output  $clog2(MAX_STEPS+1)  completed STEP iterations.
REQ-018 result_t_out  output  fp  accumulated march distance.
REQ-019 result_point_out  output  vec3  final march point.
REQ-020 result_tag_out  output  TAG_W  tag of the ray.

Function
REQ-021 FSM states IDLE, QUERY, STEP, DONE; one ray in flight at a time.
REQ-022 ray_ready_out SHALL be 1 only in IDLE with rst_in low; result_valid_out SHALL be 1 only in DONE.
REQ-023 IDLE: on ray_valid_in&ray_ready_out, latch point<=origin, dir, tag; t<=0, steps<=0; go QUERY.
REQ-024 query_point_out SHALL always equal the point register.
REQ-025 QUERY: d<=sdf_in; if sdf_in < EPSILON (signed, so negative counts) go DONE with hit=1, else go STEP.
REQ-026 STEP: point<=point+dir*d per component using the codebase fp multiply/add; t<=t+d, saturating at max positive fp; steps<=steps+1.
REQ-027 STEP exit: if steps+1==MAX_STEPS or new t>=MAX_DIST go DONE with hit=0, else go QUERY; MAX_STEPS takes priority when both hold (hit=0 either way).
REQ-028 Latency from accept at cycle 0: hit at k-th query (k prior steps) gives result_valid_out at cycle 2k+2; miss after N steps at cycle 2N+1.
REQ-029 DONE: all result_* SHALL be registered and held stable until result_valid_out&result_ready_in, then go IDLE.
REQ-030 No bypass: a new ray SHALL NOT be accepted in the cycle a result is consumed; earliest accept is the following cycle.
REQ-031 ray_valid_in and ray_*_in SHALL be ignored outside IDLE; sdf_in SHALL be ignored outside QUERY.

Reset
REQ-032 rst_in high SHALL force IDLE at the next edge, aborting any ray without producing a result.
REQ-033 Reset values: result_valid_out=0, result_hit_out=0, result_steps_out=0, result_t_out=0, result_point_out=0, result_tag_out=0, query_point_out=0, ray_ready_out=0 while rst_in high.

Structure
REQ-034 FP_EPSILON, FP_MAX_DIST and the march_state_t enum SHALL live in the shared types/constants package alongside fp and vec3.
REQ-035 The advance datapath (point+dir*d) SHALL be one combinational sub-module ray_march_advance; the SDF query is instantiated outside this block.

Verification
REQ-036 Origin (0,0,-3), dir (0,0,1), SDF = cube half-size 0.5: hit=1, steps=1, t=2.5, point (0,0,-0.5), valid at cycle 4.
REQ-037 Origin (0,0,0) inside the cube (sdf=-0.5): hit=1, steps=0, t=0, valid at cycle 2.
REQ-038 Stub sdf constant 1.0, MAX_DIST=8.0, MAX_STEPS=64: hit=0, steps=8, t=8.0, valid at cycle 17.
REQ-039 Stub sdf constant 2*EPSILON, MAX_STEPS=4: hit=0, steps=4, valid at cycle 9.
REQ-040 Hold result_ready_in low 10 cycles in DONE while pulsing ray_valid_in: results stable, ray_ready_out=0, ray not accepted; after handshake, IDLE next cycle, ray accepted the cycle after that.
REQ-041 Assert rst_in during the 3rd STEP: no result ever emitted for that ray, outputs at reset values, ray_ready_out=1 after deassert; the next ray completes with the expected results.
